// File: rtl/pwm_seq_ctrl.sv
// pwm_seq_ctrl: shadowed PWM duty sequencer with soft-start motor FSM, retry/lockout and brake fault latch
module pwm_seq_ctrl #(
    parameter int RAMP_STEP   = 16,
    parameter int RETRY_TICKS = 5,
    parameter int MAX_RETRIES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pulse_200us,
    input  logic       start_pwm_period,
    input  logic       host_wr,
    input  logic [9:0] host_duty01,
    input  logic [9:0] host_duty23,
    input  logic [9:0] host_duty45,
    input  logic [9:0] host_brk_duty,
    input  logic       host_mot_en,
    input  logic       host_brk_en,
    input  logic       mot_over_curr,
    input  logic       brk_over_curr,
    input  logic       fault_clr,
    output logic [9:0] mot_pwm_param01,
    output logic [9:0] mot_pwm_param23,
    output logic [9:0] mot_pwm_param45,
    output logic [9:0] brk_pwm_param,
    output logic       mot_en_in,
    output logic       brk_en_in,
    output logic [2:0] mot_state,
    output logic [1:0] retry_cnt,
    output logic       brk_fault
);
    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] RAMP       = 3'd1;
    localparam logic [2:0] RUN        = 3'd2;
    localparam logic [2:0] FAULT_WAIT = 3'd3;
    localparam logic [2:0] LOCKOUT    = 3'd4;
    localparam int TW = $clog2(RETRY_TICKS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(RETRY_TICKS - 1);
    localparam logic [10:0] STEP = 11'(RAMP_STEP);
    localparam logic [2:0] MAX_R = 3'(MAX_RETRIES);

    logic [2:0]    state;
    logic [TW-1:0] tick;
    logic [9:0]    sh01, sh23, sh45, shb;
    logic          brk_fault_n, brk_en_n, all_eq;

    // one bounded step toward the target, done at 11 bits so it cannot wrap
    function automatic logic [9:0] ramp(input logic [9:0] c, input logic [9:0] t);
        logic [10:0] up;
        logic [10:0] dn;
        up = {1'b0, c} + STEP;
        dn = {1'b0, c} - STEP;
        return (t > c) ? ((up >= {1'b0, t}) ? t : up[9:0])
                       : (({1'b0, c} <= {1'b0, t} + STEP) ? t : dn[9:0]);
    endfunction

    assign mot_state   = state;
    assign mot_en_in   = (state == RAMP) || (state == RUN);
    assign brk_fault_n = brk_over_curr | (brk_fault & ~fault_clr);
    assign brk_en_n    = host_brk_en & ~brk_fault_n;
    assign all_eq      = (mot_pwm_param01 == sh01) && (mot_pwm_param23 == sh23) && (mot_pwm_param45 == sh45);

    // host shadow registers
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            sh01 <= '0;
            sh23 <= '0;
            sh45 <= '0;
            shb  <= '0;
        end else if (host_wr) begin
            sh01 <= host_duty01;
            sh23 <= host_duty23;
            sh45 <= host_duty45;
            shb  <= host_brk_duty;
        end

    // brake path: sticky fault, registered enable, duty loaded at period boundaries
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            brk_fault     <= 1'b0;
            brk_en_in     <= 1'b0;
            brk_pwm_param <= '0;
        end else begin
            brk_fault     <= brk_fault_n;
            brk_en_in     <= brk_en_n;
            brk_pwm_param <= !brk_en_n ? 10'd0 : start_pwm_period ? shb : brk_pwm_param;
        end

    // motor FSM with soft-start ramp, retry counting and lockout
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state           <= IDLE;
            tick            <= '0;
            retry_cnt       <= '0;
            mot_pwm_param01 <= '0;
            mot_pwm_param23 <= '0;
            mot_pwm_param45 <= '0;
        end else if (mot_en_in && mot_over_curr) begin
            state           <= FAULT_WAIT;
            tick            <= '0;
            retry_cnt       <= (retry_cnt == 2'd3) ? 2'd3 : retry_cnt + 2'd1;
            mot_pwm_param01 <= '0;
            mot_pwm_param23 <= '0;
            mot_pwm_param45 <= '0;
        end else if (state == LOCKOUT) begin
            if (fault_clr) begin
                state     <= IDLE;
                retry_cnt <= '0;
            end
        end else begin
            if (fault_clr || (state == IDLE && !host_mot_en))
                retry_cnt <= '0;
            if (!host_mot_en) begin
                state           <= IDLE;
                mot_pwm_param01 <= '0;
                mot_pwm_param23 <= '0;
                mot_pwm_param45 <= '0;
            end else begin
                case (state)
                    IDLE: if (!mot_over_curr) state <= RAMP;
                    RAMP: begin
                        if (start_pwm_period) begin
                            mot_pwm_param01 <= ramp(mot_pwm_param01, sh01);
                            mot_pwm_param23 <= ramp(mot_pwm_param23, sh23);
                            mot_pwm_param45 <= ramp(mot_pwm_param45, sh45);
                        end
                        if (all_eq) state <= RUN;
                    end
                    RUN: if (start_pwm_period) begin
                        mot_pwm_param01 <= sh01;
                        mot_pwm_param23 <= sh23;
                        mot_pwm_param45 <= sh45;
                    end
                    FAULT_WAIT: if (pulse_200us) begin
                        tick <= tick + 1'b1;
                        if (tick == TICK_LAST)
                            state <= ({1'b0, retry_cnt} >= MAX_R) ? LOCKOUT : mot_over_curr ? IDLE : RAMP;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// tb_pwm_seq_ctrl: directed scoreboard bench for pwm_seq_ctrl
module tb_pwm_seq_ctrl;
    logic       clk = 1'b0, reset = 1'b0;
    logic       pulse_200us = 0, start_pwm_period = 0, host_wr = 0;
    logic [9:0] host_duty01 = 0, host_duty23 = 0, host_duty45 = 0, host_brk_duty = 0;
    logic       host_mot_en = 0, host_brk_en = 0, mot_over_curr = 0, brk_over_curr = 0, fault_clr = 0;
    logic [9:0] mot_pwm_param01, mot_pwm_param23, mot_pwm_param45, brk_pwm_param;
    logic       mot_en_in, brk_en_in, brk_fault;
    logic [2:0] mot_state;
    logic [1:0] retry_cnt;

    typedef struct { string tag; logic [31:0] v; } exp_t;
    exp_t q[$];
    int checks = 0, errors = 0;

    pwm_seq_ctrl dut (
        .clk(clk), .reset(reset), .pulse_200us(pulse_200us), .start_pwm_period(start_pwm_period),
        .host_wr(host_wr), .host_duty01(host_duty01), .host_duty23(host_duty23),
        .host_duty45(host_duty45), .host_brk_duty(host_brk_duty), .host_mot_en(host_mot_en),
        .host_brk_en(host_brk_en), .mot_over_curr(mot_over_curr), .brk_over_curr(brk_over_curr),
        .fault_clr(fault_clr), .mot_pwm_param01(mot_pwm_param01), .mot_pwm_param23(mot_pwm_param23),
        .mot_pwm_param45(mot_pwm_param45), .brk_pwm_param(brk_pwm_param), .mot_en_in(mot_en_in),
        .brk_en_in(brk_en_in), .mot_state(mot_state), .retry_cnt(retry_cnt), .brk_fault(brk_fault)
    );

    always #5 clk = ~clk;

    task automatic expect_v(input string t, input logic [31:0] v);
        exp_t e;
        e.tag = t;
        e.v = v;
        q.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed %0h", obs);
        end else begin
            e = q.pop_front();
            assert (obs === e.v) else begin
                errors++;
                $error("FAIL %s observed %0h expected %0h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic boundary();
        start_pwm_period = 1;
        cyc(1);
        start_pwm_period = 0;
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            pulse_200us = 1;
            cyc(1);
            pulse_200us = 0;
            cyc(1);
        end
    endtask

    initial begin
        #3;
        expect_v("rst_state", 0); expect_v("rst_p01", 0); expect_v("rst_mot_en", 0);
        expect_v("rst_retry", 0); expect_v("rst_brk_fault", 0); expect_v("rst_brk_en", 0);
        chk(mot_state); chk(mot_pwm_param01); chk(mot_en_in);
        chk(retry_cnt); chk(brk_fault); chk(brk_en_in);
        cyc(1);
        reset = 1;
        cyc(1);

        // soft start
        host_duty01 = 10'h100; host_duty23 = 10'h080; host_duty45 = 10'h050;
        host_wr = 1; host_mot_en = 1;
        expect_v("enter_ramp", 1); expect_v("ramp_mot_en", 1);
        cyc(1);
        host_wr = 0;
        chk(mot_state); chk(mot_en_in);
        for (int b = 1; b <= 16; b++) begin
            expect_v($sformatf("ramp_p01_b%0d", b), 16 * b);
            expect_v($sformatf("ramp_p23_b%0d", b), (16 * b > 128) ? 128 : 16 * b);
            expect_v($sformatf("ramp_p45_b%0d", b), (16 * b > 80) ? 80 : 16 * b);
            expect_v($sformatf("ramp_state_b%0d", b), 1);
            boundary();
            chk(mot_pwm_param01); chk(mot_pwm_param23); chk(mot_pwm_param45); chk(mot_state);
            cyc(1);
        end
        expect_v("run_state", 2);
        chk(mot_state);

        // write coinciding with boundary keeps old shadow
        host_duty01 = 10'h200;
        host_wr = 1;
        expect_v("coinc_old", 10'h100);
        boundary();
        host_wr = 0;
        chk(mot_pwm_param01);
        cyc(1);
        expect_v("coinc_new", 10'h200);
        boundary();
        chk(mot_pwm_param01);

        // fault and retry
        mot_over_curr = 1;
        expect_v("f1_state", 3); expect_v("f1_mot_en", 0); expect_v("f1_p01", 0); expect_v("f1_retry", 1);
        cyc(1);
        mot_over_curr = 0;
        chk(mot_state); chk(mot_en_in); chk(mot_pwm_param01); chk(retry_cnt);
        wait_ticks(4);
        expect_v("f1_wait4", 3);
        chk(mot_state);
        wait_ticks(1);
        expect_v("f1_back_ramp", 1); expect_v("f1_ramp_p01", 0);
        chk(mot_state); chk(mot_pwm_param01);

        // two more faults lead to lockout
        for (int k = 2; k <= 3; k++) begin
            mot_over_curr = 1;
            expect_v($sformatf("f%0d_retry", k), k);
            cyc(1);
            mot_over_curr = 0;
            chk(retry_cnt);
            wait_ticks(5);
        end
        expect_v("lock_state", 4); expect_v("lock_mot_en", 0); expect_v("lock_p01", 0);
        chk(mot_state); chk(mot_en_in); chk(mot_pwm_param01);
        host_mot_en = 0;
        cyc(2);
        host_mot_en = 1;
        cyc(2);
        expect_v("lock_hold", 4); expect_v("lock_retry", 3);
        chk(mot_state); chk(retry_cnt);
        fault_clr = 1;
        expect_v("clr_state", 0); expect_v("clr_retry", 0);
        cyc(1);
        fault_clr = 0;
        chk(mot_state); chk(retry_cnt);

        // brake path
        host_brk_en = 1; host_brk_duty = 10'h0AA; host_wr = 1;
        cyc(1);
        host_wr = 0;
        expect_v("brk_en", 1); expect_v("brk_duty", 10'h0AA);
        boundary();
        chk(brk_en_in); chk(brk_pwm_param);
        brk_over_curr = 1;
        expect_v("brkf_set", 1); expect_v("brkf_en", 0); expect_v("brkf_duty", 0);
        expect_v("brkf_mot_en", 1); expect_v("brkf_mot_state", 1);
        cyc(1);
        brk_over_curr = 0;
        chk(brk_fault); chk(brk_en_in); chk(brk_pwm_param); chk(mot_en_in); chk(mot_state);
        brk_over_curr = 1; fault_clr = 1;
        expect_v("brkf_set_wins", 1);
        cyc(1);
        brk_over_curr = 0;
        chk(brk_fault);
        expect_v("brkf_clr", 0); expect_v("brkf_clr_en", 1);
        cyc(1);
        fault_clr = 0;
        chk(brk_fault); chk(brk_en_in);

        // async reset mid-ramp
        #3 reset = 0;
        #1;
        expect_v("arst_state", 0); expect_v("arst_p01", 0); expect_v("arst_mot_en", 0);
        expect_v("arst_brk_en", 0); expect_v("arst_brk_duty", 0);
        chk(mot_state); chk(mot_pwm_param01); chk(mot_en_in); chk(brk_en_in); chk(brk_pwm_param);
        #2 reset = 1;
        expect_v("resume_ramp", 1);
        cyc(1);
        chk(mot_state);

        if (q.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover observed %0d expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pwm_seq_ctrl.md
PWM_SEQ_CTRL -- requirements
Module: pwm_seq_ctrl

Interface
REQ-001 SHALL have parameter RAMP_STEP, default 16: maximum per-period change of a motor duty during RAMP.
REQ-002 SHALL have parameter RETRY_TICKS, default 5: number of pulse_200us ticks spent in FAULT_WAIT.
REQ-003 SHALL have parameter MAX_RETRIES, default 3: number of motor faults that forces LOCKOUT.
REQ-004 SHALL have ports, listed as name, direction, width, meaning:
- clk, in, 1: the only clock.
- reset, in, 1: asynchronous, active-low reset.
- pulse_200us, in, 1: one-clk timebase tick.
- start_pwm_period, in, 1: one-clk PWM period boundary.
- host_wr, in, 1: shadow-register write strobe.
- host_duty01, host_duty23, host_duty45, host_brk_duty, in, 10 each: requested duties.
- host_mot_en, host_brk_en, in, 1 each: host enables.
- mot_over_curr, brk_over_curr, in, 1 each: fault inputs.
- fault_clr, in, 1: one-clk fault clear.
- mot_pwm_param01, mot_pwm_param23, mot_pwm_param45, brk_pwm_param, out, 10 each: active duties.
- mot_en_in, brk_en_in, out, 1 each: enables.
- mot_state, out, 3: FSM state.
- retry_cnt, out, 2: motor fault count.
- brk_fault, out, 1: latched brake fault.

Function
REQ-005 SHALL capture all four host_duty values into shadow registers on the clk edge where host_wr=1.
REQ-006 SHALL change active duty outputs only on clk edges where start_pwm_period=1; when host_wr and start_pwm_period coincide, the active outputs take the OLD shadow values.
REQ-007 SHALL implement motor FSM states with these encodings: IDLE=0, RAMP=1, RUN=2, FAULT_WAIT=3, LOCKOUT=4.
REQ-008 In IDLE, SHALL hold mot_en_in=0 and all motor params at 0.
REQ-009 In IDLE, SHALL go to RAMP when host_mot_en=1 and mot_over_curr=0.
REQ-010 In RAMP, SHALL hold mot_en_in=1.
REQ-011 In RAMP, at each period boundary, SHALL move each motor param toward its shadow by at most RAMP_STEP, without overshoot, in either direction.
REQ-012 SHALL perform the RAMP step arithmetic at 11-bit width so the result never wraps past 1023 or below 0.
REQ-013 SHALL go from RAMP to RUN on the edge after all three motor params equal their shadows.
REQ-014 In RUN, SHALL hold mot_en_in=1 and copy the shadows directly to the motor params at each boundary.
REQ-015 On mot_over_curr=1 in RAMP or RUN, SHALL on the next edge: enter FAULT_WAIT, set mot_en_in=0, zero the motor params, and increment retry_cnt (saturating at 3).
REQ-016 SHALL give fault priority over a coincident start_pwm_period or host_mot_en drop.
REQ-017 In FAULT_WAIT, SHALL count pulse_200us ticks; on reaching RETRY_TICKS:
- if retry_cnt >= MAX_RETRIES, go to LOCKOUT;
- else if host_mot_en=1 and mot_over_curr=0, go to RAMP with params starting from 0;
- else go to IDLE.
REQ-018 SHALL clear the tick counter on every entry to FAULT_WAIT.
REQ-019 In LOCKOUT, SHALL hold mot_en_in=0 and params 0, ignore host_mot_en, and leave only on fault_clr=1, going to IDLE with retry_cnt cleared.
REQ-020 In IDLE, RAMP, RUN and FAULT_WAIT, host_mot_en=0 SHALL force IDLE on the next edge.
REQ-021 SHALL clear retry_cnt whenever the FSM is in IDLE with host_mot_en=0, or on fault_clr outside LOCKOUT.
REQ-022 SHALL set brk_fault on brk_over_curr=1 and clear it on fault_clr=1; set wins when both occur in the same cycle.
REQ-023 SHALL drive brk_en_in = host_brk_en AND NOT brk_fault, registered.
REQ-024 SHALL load brk_pwm_param from its shadow at each boundary while brk_en_in=1, and hold it at 0 otherwise.
REQ-025 SHALL treat the brake and motor fault paths as independent.
REQ-026 When mot_over_curr and fault_clr coincide, fault SHALL win.

Reset
REQ-027 While reset=0, SHALL asynchronously set all outputs, shadows, counters and brk_fault to 0, with the FSM in IDLE.
REQ-028 SHALL resume operation on the first clk edge after reset rises.
REQ-029 Reset mid-RAMP or mid-FAULT_WAIT SHALL discard all progress.

Verification
REQ-030 Soft-start: shadows 0x100/0x080/0x050, host_mot_en=1, start pulses -> param01 steps 0,16,32,...,256 and reaches RUN after 16 boundaries; param45 holds 0x050 from boundary 5.
REQ-031 Write/boundary coincidence: in RUN, host_wr with 0x200 coincides with start -> output keeps the old value; 0x200 appears at the next boundary.
REQ-032 Fault and retry: one-clk mot_over_curr in RUN -> next edge mot_en_in=0, params 0, retry_cnt=1; after 5 pulse_200us ticks -> RAMP from 0.
REQ-033 Lockout: three faults -> LOCKOUT (state 4); host_mot_en toggling has no effect; fault_clr -> IDLE, retry_cnt=0.
REQ-034 Brake fault: brk_over_curr pulse -> brk_en_in=0 next edge, brk_pwm_param 0, motor unaffected; fault_clr and brk_over_curr in the same cycle -> brk_fault stays 1.
REQ-035 Async reset asserted mid-RAMP, between clk edges -> all outputs 0 immediately.
